pipe_datapath_fwd: RTL and testbench
====================================

Name: pipe_datapath_fwd

Overview:
- Parametrised 5-stage (F/D/E/M/W) pipelined integer datapath; next generation of the team's pipelined MIPS-subset datapath.
- Adds data forwarding, load-use stall and branch flush, so back-to-back dependent code runs correctly without NOPs.
- Generalised data width, register-file depth and PC width.
- Control decode stays in the external controller (driven in D). Instruction and data memories are external, with combinational reads.

Parameters:
DATA_W, 32, datapath/register width
REG_AW, 5, register address width (2**REG_AW registers; r0 hardwired zero)
PC_W, 6, word-addressed PC / memory address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_addr  out  PC_W  fetch address (= PC)
imem_rdata  in  32  instruction at imem_addr (combinational)
dmem_addr  out  PC_W  ALUOutM[PC_W-1:0]
dmem_wdata  out  DATA_W  WriteDataM
dmem_we  out  1  MemWriteM
dmem_rdata  in  DATA_W  data at dmem_addr (combinational)
OpcodeD  out  6  InstrD[31:26] to controller
FunctD  out  6  InstrD[5:0] to controller
RegWriteD, MemToRegD, MemWriteD, BranchD, ALUSrcD, RegDstD  in  1 each  decode-stage control
ALUControlD  in  3  010 add, 110 sub, 000 and, 001 or, 111 slt
stall_o  out  1  load-use stall active this cycle
flush_o  out  1  taken-branch flush active this cycle

Behaviour:
- Reset (reset=0, async):
  - PC=0; regfile all 0.
  - All pipeline registers cleared. Cleared control bits form bubbles (RegWrite=MemWrite=Branch=0).
  - dmem_we=0, stall_o=0, flush_o=0.
- F:
  - imem_addr=PC. PC<=PC+1 (mod 2**PC_W) unless stalled or redirected.
  - F/D register captures the instruction and PC+1.
- D:
  - Decode: Rs=[25:21], Rt=[20:16], Rd=[15:11], each truncated to REG_AW.
  - Imm [15:0] sign-extended to DATA_W.
  - Regfile has 2 combinational read ports.
  - Write-through: if W writes register X (X≠0) in the same cycle D reads X, D gets ResultW.
- E:
  - WriteRegE = RegDstE ? RdE : RtE.
  - SrcB = ALUSrcE ? SignImmE : forwarded Rt value.
  - ALU result is DATA_W wide; slt is signed; zero flag = (result==0).
- Forwarding (applies independently to SrcA and to the Rt value):
  - If RegWriteM and WriteRegM≠0 and WriteRegM==RsE/RtE, use ALUOutM.
  - Else if RegWriteW and WriteRegW≠0 and match, use ResultW.
  - Else use the registered value.
  - M has priority over W.
- M:
  - dmem signals are driven from the M/E register.
  - Only the load data is sampled into M/W.
- W:
  - ResultW = MemToRegW ? ReadDataW : ALUOutW.
  - Regfile writes on the clock edge when RegWriteW and WriteRegW≠0.
  - Writes to r0 are ignored; r0 always reads 0.
- Load-use stall:
  - Condition: MemToRegE & RegWriteE & WriteRegE≠0 & (WriteRegE==RsD | WriteRegE==RtD).
  - Effect: PC and F/D hold; D/E is loaded with a bubble; stall_o=1.
  - Lasts exactly 1 cycle per hazard.
- Branch (beq, resolved in E):
  - Taken = BranchE & zero.
  - Taken: PC <= PCPlus1E + SignImmE (truncated to PC_W). F/D and D/E load bubbles; flush_o=1.
  - Penalty: 2 cycles. Not taken: no penalty.
- Simultaneous stall and flush: flush wins. The PC is redirected and the stalled D instruction is discarded.
- Wrap-around: PC and branch target wrap modulo 2**PC_W.
- Reset mid-operation: all in-flight instructions are discarded. No dmem write may be issued in the reset cycle or the first post-reset cycle. Fetch restarts at 0.

Test Plan:
1. addi r1,r0,5; add r2,r1,r1; sub r3,r2,r1 back-to-back -> r2=10, r3=5 via M/W forwarding, no stall_o.
2. lw r4,0(r0) with mem[0]=0x1234; add r5,r4,r4 -> stall_o high exactly 1 cycle, r5=0x2468.
3. beq r0,r0,+3 followed by two addi to r6 -> flush_o 1 cycle, r6 stays 0, next PC = branch PC+4.
4. addi r0,r0,7; add r7,r0,r0 -> r7=0; r0 reads 0.
5. sw r1,2(r0) with r1=5, then lw r8,2(r0) -> dmem_we pulse with addr 2, data 5; r8=5.
6. Assert reset low mid-stream with a sw in E -> PC=0, no dmem_we, all regs 0 immediately (async); correct execution restarts after release.

Source files
------------

// File: rtl/pipe_datapath_fwd.sv
// 5-stage F/D/E/M/W integer datapath with forwarding, load-use stall, beq flush.
// Ports: clk/reset (async, active-low); imem_* fetch; dmem_* data memory (M stage);
//   OpcodeD/FunctD to the external controller, *D control bits back from it;
//   stall_o/flush_o report load-use stall and taken-branch flush this cycle.
module pipe_datapath_fwd #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [PC_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [5:0]        OpcodeD,
  output logic [5:0]        FunctD,
  input  logic              RegWriteD,
  input  logic              MemToRegD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic              RegDstD,
  input  logic [2:0]        ALUControlD,
  output logic              stall_o,
  output logic              flush_o
);

  localparam int NREG = 2 ** REG_AW;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pcp1;
  } if_id_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              branch;
    logic              alu_src;
    logic              reg_dst;
    logic [2:0]        alu_ctl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pcp1;
  } id_ex_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] wdata;
    logic [REG_AW-1:0] wreg;
  } ex_mem_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu_out;
    logic [REG_AW-1:0] wreg;
  } mem_wb_t;

  logic [PC_W-1:0]   pc_q, pc_d;
  if_id_t            fd_q, fd_d;
  id_ex_t            de_q, de_d;
  ex_mem_t           em_q, em_d;
  mem_wb_t           mw_q, mw_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic [REG_AW-1:0] d_rs, d_rt, d_rd;
  logic [DATA_W-1:0] d_imm, d_rd1, d_rd2;
  logic [REG_AW-1:0] e_wreg;
  logic [DATA_W-1:0] e_fwd_a, e_fwd_b, e_src_b, e_alu;
  logic [PC_W-1:0]   e_target;
  logic              e_taken, m_fwd, ld_use;
  logic [DATA_W-1:0] w_result;
  logic              w_we;
  logic              unused_shamt;

  assign unused_shamt = ^fd_q.instr[10:6];

  // W stage
  assign w_result = mw_q.mem_to_reg ? mw_q.rdata : mw_q.alu_out;
  assign w_we     = mw_q.reg_write && (mw_q.wreg != '0);

  // D stage
  assign d_rs  = fd_q.instr[21 +: REG_AW];
  assign d_rt  = fd_q.instr[16 +: REG_AW];
  assign d_rd  = fd_q.instr[11 +: REG_AW];
  assign d_imm = {{(DATA_W-16){fd_q.instr[15]}}, fd_q.instr[15:0]};

  // Same-cycle W write is passed straight through to the D read.
  always_comb begin
    d_rd1 = rf_q[d_rs];
    d_rd2 = rf_q[d_rt];
    if (d_rs == '0)
      d_rd1 = '0;
    else if (w_we && mw_q.wreg == d_rs)
      d_rd1 = w_result;
    if (d_rt == '0)
      d_rd2 = '0;
    else if (w_we && mw_q.wreg == d_rt)
      d_rd2 = w_result;
  end

  // E stage with M-over-W forwarding
  assign e_wreg = de_q.reg_dst ? de_q.rd : de_q.rt;
  assign m_fwd  = em_q.reg_write && (em_q.wreg != '0);

  always_comb begin
    e_fwd_a = de_q.rd1;
    e_fwd_b = de_q.rd2;
    if (m_fwd && em_q.wreg == de_q.rs)
      e_fwd_a = em_q.alu_out;
    else if (w_we && mw_q.wreg == de_q.rs)
      e_fwd_a = w_result;
    if (m_fwd && em_q.wreg == de_q.rt)
      e_fwd_b = em_q.alu_out;
    else if (w_we && mw_q.wreg == de_q.rt)
      e_fwd_b = w_result;
  end

  assign e_src_b = de_q.alu_src ? de_q.imm : e_fwd_b;

  always_comb begin
    e_alu = '0;
    case (de_q.alu_ctl)
      3'b010:  e_alu = e_fwd_a + e_src_b;
      3'b110:  e_alu = e_fwd_a - e_src_b;
      3'b000:  e_alu = e_fwd_a & e_src_b;
      3'b001:  e_alu = e_fwd_a | e_src_b;
      3'b111:  e_alu = ($signed(e_fwd_a) < $signed(e_src_b))
                       ? DATA_W'(1) : '0;
      default: e_alu = '0;
    endcase
  end

  assign e_taken  = de_q.branch && (e_alu == '0);
  assign e_target = de_q.pcp1 + de_q.imm[PC_W-1:0];

  // Hazard unit; a load and a branch never share E, flush still wins.
  assign ld_use = de_q.mem_to_reg && de_q.reg_write && (e_wreg != '0)
                  && (e_wreg == d_rs || e_wreg == d_rt);
  assign flush_o = e_taken;
  assign stall_o = ld_use && !e_taken;

  // Outputs
  assign imem_addr  = pc_q;
  assign OpcodeD    = fd_q.instr[31:26];
  assign FunctD     = fd_q.instr[5:0];
  assign dmem_addr  = em_q.alu_out[PC_W-1:0];
  assign dmem_wdata = em_q.wdata;
  assign dmem_we    = em_q.mem_write;

  always_comb begin
    pc_d       = pc_q + PC_W'(1);
    fd_d.instr = imem_rdata;
    fd_d.pcp1  = pc_q + PC_W'(1);
    if (e_taken) begin
      pc_d = e_target;
      fd_d = '0;
    end else if (ld_use) begin
      pc_d = pc_q;
      fd_d = fd_q;
    end
  end

  always_comb begin
    de_d.reg_write  = RegWriteD;
    de_d.mem_to_reg = MemToRegD;
    de_d.mem_write  = MemWriteD;
    de_d.branch     = BranchD;
    de_d.alu_src    = ALUSrcD;
    de_d.reg_dst    = RegDstD;
    de_d.alu_ctl    = ALUControlD;
    de_d.rd1        = d_rd1;
    de_d.rd2        = d_rd2;
    de_d.rs         = d_rs;
    de_d.rt         = d_rt;
    de_d.rd         = d_rd;
    de_d.imm        = d_imm;
    de_d.pcp1       = fd_q.pcp1;
    if (e_taken || ld_use)
      de_d = '0;
  end

  always_comb begin
    em_d.reg_write  = de_q.reg_write;
    em_d.mem_to_reg = de_q.mem_to_reg;
    em_d.mem_write  = de_q.mem_write;
    em_d.alu_out    = e_alu;
    em_d.wdata      = e_fwd_b;
    em_d.wreg       = e_wreg;
  end

  always_comb begin
    mw_d.reg_write  = em_q.reg_write;
    mw_d.mem_to_reg = em_q.mem_to_reg;
    mw_d.rdata      = dmem_rdata;
    mw_d.alu_out    = em_q.alu_out;
    mw_d.wreg       = em_q.wreg;
  end

  always_comb begin
    rf_d = rf_q;
    if (w_we)
      rf_d[mw_q.wreg] = w_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      fd_q <= '0;
      de_q <= '0;
      em_q <= '0;
      mw_q <= '0;
      rf_q <= '{default: '0};
    end else begin
      pc_q <= pc_d;
      fd_q <= fd_d;
      de_q <= de_d;
      em_q <= em_d;
      mw_q <= mw_d;
      rf_q <= rf_d;
    end
  end

endmodule

// File: tb/tb_pipe_datapath_fwd.sv
// Bench for pipe_datapath_fwd: directed program, behavioural memories
// and controller; a monitor scores stores, stalls and flushes.
module tb_pipe_datapath_fwd;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [PW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_we;
  logic [DW-1:0] dmem_rdata;
  logic [5:0]    OpcodeD, FunctD;
  logic          RegWriteD, MemToRegD, MemWriteD;
  logic          BranchD, ALUSrcD, RegDstD;
  logic [2:0]    ALUControlD;
  logic          stall_o, flush_o;

  always #5 clk = ~clk;

  pipe_datapath_fwd #(.DATA_W(DW), .REG_AW(AW), .PC_W(PW)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .OpcodeD(OpcodeD), .FunctD(FunctD),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD),
    .MemWriteD(MemWriteD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .ALUControlD(ALUControlD),
    .stall_o(stall_o), .flush_o(flush_o)
  );

  logic [31:0] imem [64];
  logic [31:0] dmem [64];

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk)
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;

  // Reference controller
  always_comb begin
    RegWriteD   = 1'b0;
    MemToRegD   = 1'b0;
    MemWriteD   = 1'b0;
    BranchD     = 1'b0;
    ALUSrcD     = 1'b0;
    RegDstD     = 1'b0;
    ALUControlD = 3'b010;
    case (OpcodeD)
      6'h00: begin
        RegDstD   = 1'b1;
        RegWriteD = 1'b1;
        case (FunctD)
          6'h20:   ALUControlD = 3'b010;
          6'h22:   ALUControlD = 3'b110;
          6'h24:   ALUControlD = 3'b000;
          6'h25:   ALUControlD = 3'b001;
          6'h2a:   ALUControlD = 3'b111;
          default: RegWriteD   = 1'b0;
        endcase
      end
      6'h08: begin RegWriteD = 1'b1; ALUSrcD = 1'b1; end
      6'h23: begin
        RegWriteD = 1'b1; ALUSrcD = 1'b1; MemToRegD = 1'b1;
      end
      6'h2b: begin MemWriteD = 1'b1; ALUSrcD = 1'b1; end
      6'h04: begin BranchD = 1'b1; ALUControlD = 3'b110; end
      default: ;
    endcase
  end

  function automatic logic [31:0] r_op(input logic [5:0] f,
    input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, f};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op,
    input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } st_t;

  st_t st_q[$];
  int  stall_q[$];
  int  flush_q[$];
  st_t st_e;
  int  cyc_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_st(input logic [5:0] a, input logic [31:0] d);
    st_t s;
    s.a = a;
    s.d = d;
    st_q.push_back(s);
  endtask

  // Timing in cycles since reset release (instr 0 fetched in cycle 0).
  task automatic push_expect();
    push_st(6'd16, 32'd10);
    push_st(6'd17, 32'd5);
    push_st(6'd18, 32'h2468);
    push_st(6'd19, 32'd0);
    push_st(6'd20, 32'd0);
    push_st(6'd2,  32'd5);
    push_st(6'd22, 32'd5);
    push_st(6'd23, 32'd1);
    push_st(6'd24, 32'd15);
    push_st(6'd25, 32'hFFFF_FFFB);
    stall_q.push_back(7);
    stall_q.push_back(19);
    flush_q.push_back(11);
    flush_q.push_back(29);
    flush_q.push_back(32);
    flush_q.push_back(35);
    flush_q.push_back(38);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (dmem_we) begin
        if (st_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL store_extra: got addr %0d data %0h expected none",
                   dmem_addr, dmem_wdata);
        end else begin
          st_e = st_q.pop_front();
          chk("store", {26'd0, dmem_addr, dmem_wdata}, {26'd0, st_e.a, st_e.d});
        end
      end
      if (stall_o) begin
        if (stall_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stall_extra: got stall at cycle %0d expected none", cyc);
        end else begin
          cyc_e = stall_q.pop_front();
          chk("stall_cycle", 64'(cyc), 64'(cyc_e));
        end
      end
      if (flush_o) begin
        if (flush_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL flush_extra: got flush at cycle %0d expected none", cyc);
        end else begin
          cyc_e = flush_q.pop_front();
          chk("flush_cycle", 64'(cyc), 64'(cyc_e));
        end
      end
    end
  end

  task automatic queues_empty(input string nm);
    chk({nm, "_stores_left"}, 64'(st_q.size()), 64'd0);
    chk({nm, "_stalls_left"}, 64'(stall_q.size()), 64'd0);
    chk({nm, "_flushes_left"}, 64'(flush_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
    dmem[0] = 32'h1234;
    imem[0]  = i_op(6'h08, 5'd1, 5'd0, 16'd5);
    imem[1]  = r_op(6'h20, 5'd2, 5'd1, 5'd1);
    imem[2]  = r_op(6'h22, 5'd3, 5'd2, 5'd1);
    imem[3]  = i_op(6'h2b, 5'd2, 5'd0, 16'd16);
    imem[4]  = i_op(6'h2b, 5'd3, 5'd0, 16'd17);
    imem[5]  = i_op(6'h23, 5'd4, 5'd0, 16'd0);
    imem[6]  = r_op(6'h20, 5'd5, 5'd4, 5'd4);
    imem[7]  = i_op(6'h2b, 5'd5, 5'd0, 16'd18);
    imem[8]  = i_op(6'h04, 5'd0, 5'd0, 16'd3);
    imem[9]  = i_op(6'h08, 5'd6, 5'd0, 16'd1);
    imem[10] = i_op(6'h08, 5'd6, 5'd6, 16'd2);
    imem[11] = i_op(6'h08, 5'd6, 5'd0, 16'd9);
    imem[12] = i_op(6'h2b, 5'd6, 5'd0, 16'd19);
    imem[13] = i_op(6'h08, 5'd0, 5'd0, 16'd7);
    imem[14] = r_op(6'h20, 5'd7, 5'd0, 5'd0);
    imem[15] = i_op(6'h2b, 5'd7, 5'd0, 16'd20);
    imem[16] = i_op(6'h2b, 5'd1, 5'd0, 16'd2);
    imem[17] = i_op(6'h23, 5'd8, 5'd0, 16'd2);
    imem[18] = i_op(6'h2b, 5'd8, 5'd0, 16'd22);
    imem[19] = r_op(6'h22, 5'd10, 5'd0, 5'd1);
    imem[20] = r_op(6'h2a, 5'd11, 5'd10, 5'd1);
    imem[21] = i_op(6'h2b, 5'd11, 5'd0, 16'd23);
    imem[22] = r_op(6'h25, 5'd12, 5'd2, 5'd1);
    imem[23] = i_op(6'h2b, 5'd12, 5'd0, 16'd24);
    imem[24] = i_op(6'h04, 5'd2, 5'd1, 16'd5);
    imem[25] = i_op(6'h2b, 5'd10, 5'd0, 16'd25);
    imem[26] = i_op(6'h04, 5'd0, 5'd0, 16'hFFFF);
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", 64'(imem_addr), 64'd0);
    chk("rst_we", 64'(dmem_we), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_flush", 64'(flush_o), 64'd0);

    // Run 1: full program
    push_expect();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (40) @(negedge clk);
    #1 queues_empty("run1");

    // Run 2: reset while the first sw sits in E
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("mid_sw_in_e", 64'(dut.de_q.mem_write), 64'd1);
    chk("mid_r1_pre", 64'(dut.rf_q[1]), 64'd5);
    reset = 1'b0;
    #1;
    chk("mid_pc", 64'(imem_addr), 64'd0);
    chk("mid_we", 64'(dmem_we), 64'd0);
    chk("mid_stall", 64'(stall_o), 64'd0);
    chk("mid_flush", 64'(flush_o), 64'd0);
    chk("mid_r1", 64'(dut.rf_q[1]), 64'd0);
    @(posedge clk);
    #1 chk("mid_we_hold", 64'(dmem_we), 64'd0);
    chk("mid_no_store_r2", 64'(dmem[16]), 64'd10);

    // Run 3: restart after release
    push_expect();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (40) @(negedge clk);
    #1 queues_empty("run3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
